fft_bf_stage_32: RTL and testbench

Radix-2 single-path delay-feedback (SDF) butterfly stage with a 32-entry feedback buffer. It sits directly downstream of the 32-twiddle ROM stage and consumes that ROM's `state`, `w_r` and `w_i` in the same cycle. It buffers the first half of each 64-sample block, produces sums and differences, and multiplies the delayed differences by the supplied Q8 twiddles. Output is one complex sample per cycle to the next stage.

---
 rtl/fft_bf_stage_32_if.sv | 25 ++
 rtl/fft_bf_stage_32.sv | 110 +++++++++++
 tb/tb_fft_bf_stage_32.sv | 380 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_bf_stage_32_if.sv
// Sample/twiddle bus into the SDF butterfly stage and the processed sample bus out of it.
// Valid-only handshake: in_valid/out_valid qualify their data in the same cycle; there is no ready, the stage never stalls.
interface fft_bf_stage_32_if #(
    parameter int DW = 24
);
    logic                 in_valid;
    logic signed [DW-1:0] din_r;
    logic signed [DW-1:0] din_i;
    logic [1:0]           state;
    logic signed [DW-1:0] w_r;
    logic signed [DW-1:0] w_i;
    logic                 out_valid;
    logic signed [DW-1:0] dout_r;
    logic signed [DW-1:0] dout_i;

    modport master (
        output in_valid, din_r, din_i, state, w_r, w_i,
        input  out_valid, dout_r, dout_i
    );

    modport slave (
        input  in_valid, din_r, din_i, state, w_r, w_i,
        output out_valid, dout_r, dout_i
    );
endinterface

// File: rtl/fft_bf_stage_32.sv
// Radix-2 SDF butterfly stage with a 32-entry feedback buffer, driven by the twiddle ROM's phase and twiddles.
// One complex sample per cycle in and out; single-cycle output latency.
module fft_bf_stage_32 #(
    parameter int DW    = 24,
    parameter int FRAC  = 8,
    parameter int DEPTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    fft_bf_stage_32_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int W2 = 2 * DW;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    typedef enum logic [1:0] {
        PH_FILL  = 2'd0,
        PH_BFLY  = 2'd1,
        PH_TWID  = 2'd2,
        PH_SPARE = 2'd3
    } phase_t;

    phase_t               phase;
    logic [PW-1:0]        ptr;
    logic [W2-1:0]        fb_mem [DEPTH];
    logic                 advance;
    logic                 emit;
    logic signed [DW-1:0] x_r, x_i;
    logic signed [DW-1:0] a_r, a_i;
    logic signed [DW-1:0] sum_r, sum_i;
    logic signed [DW-1:0] dif_r, dif_i;
    logic signed [DW-1:0] op_r, op_i;
    logic signed [DW-1:0] wr_r, wr_i;
    logic signed [W2-1:0] acc_r, acc_i;
    logic signed [W2-1:0] sh_r, sh_i;

    always_comb begin
        phase   = phase_t'(bus.state);
        advance = 1'b0;
        emit    = 1'b0;
        // Idle input in the butterfly/twiddle phases reads as zero so the buffer drains.
        x_r     = bus.in_valid ? bus.din_r : '0;
        x_i     = bus.in_valid ? bus.din_i : '0;
        a_r     = fb_mem[ptr][W2-1:DW];
        a_i     = fb_mem[ptr][DW-1:0];
        sum_r   = a_r + x_r;
        sum_i   = a_i + x_i;
        dif_r   = a_r - x_r;
        dif_i   = a_i - x_i;
        op_r    = a_r;
        op_i    = a_i;
        wr_r    = x_r;
        wr_i    = x_i;
        case (phase)
            PH_BFLY: begin
                advance = 1'b1;
                emit    = 1'b1;
                op_r    = sum_r;
                op_i    = sum_i;
                wr_r    = dif_r;
                wr_i    = dif_i;
            end
            PH_TWID: begin
                advance = 1'b1;
                emit    = 1'b1;
            end
            default: begin
                advance = bus.in_valid;
            end
        endcase
        acc_r = W2'(op_r) * W2'(bus.w_r) - W2'(op_i) * W2'(bus.w_i);
        acc_i = W2'(op_r) * W2'(bus.w_i) + W2'(op_i) * W2'(bus.w_r);
        sh_r  = acc_r >>> FRAC;
        sh_i  = acc_i >>> FRAC;
    end

    // Buffer is flops, not RAM, so reset clears every entry at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                fb_mem[i] <= '0;
            end
        end else if (advance) begin
            fb_mem[ptr] <= {wr_r, wr_i};
        end
    end

    // Tracks the ROM's phase counter low bits: one step per advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (ptr == LAST) ? '0 : ptr + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.dout_r    <= '0;
            bus.dout_i    <= '0;
        end else begin
            bus.out_valid <= emit;
            if (emit) begin
                bus.dout_r <= sh_r[DW-1:0];
                bus.dout_i <= sh_i[DW-1:0];
            end
        end
    end
endmodule

// File: tb/tb_fft_bf_stage_32.sv
// Bench for fft_bf_stage_32: drives ROM-like phase sequences and checks against a block-level DFT-butterfly model.
module tb_fft_bf_stage_32;
    localparam int DW    = 24;
    localparam int FRAC  = 8;
    localparam int DEPTH = 32;
    localparam int HALF  = 32;
    localparam int BLK   = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fft_bf_stage_32_if #(.DW(DW)) bus ();
    fft_bf_stage_32 #(.DW(DW), .FRAC(FRAC), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [2*DW-1:0]      exp_q[$];
    logic signed [DW-1:0] smp_r[$];
    logic signed [DW-1:0] smp_i[$];
    bit                   smp_drop[$];
    logic signed [DW-1:0] got_r[$];
    logic signed [DW-1:0] got_i[$];
    logic signed [DW-1:0] tw_r[HALF];
    logic signed [DW-1:0] tw_i[HALF];
    logic signed [DW-1:0] last_r, last_i;
    int cyc_cnt, first_valid, last_valid, n_valid, abort_at;
    bit aborted;

    function automatic logic signed [DW-1:0] rnd_dw();
        return DW'($urandom());
    endfunction

    // Reference: per block, 32 wrapped sums x[k]+x[k+32], then 32 wrapped differences times W64^k, floored by FRAC.
    function automatic void build_model(input int nblk);
        logic signed [DW-1:0] x0r, x0i, x1r, x1i, sr, si, orr, oi;
        longint pr, pi;
        exp_q.delete();
        for (int b = 0; b < nblk; b++) begin
            for (int k = 0; k < HALF; k++) begin
                x0r = smp_drop[b*BLK+k] ? '0 : smp_r[b*BLK+k];
                x0i = smp_drop[b*BLK+k] ? '0 : smp_i[b*BLK+k];
                x1r = smp_drop[b*BLK+HALF+k] ? '0 : smp_r[b*BLK+HALF+k];
                x1i = smp_drop[b*BLK+HALF+k] ? '0 : smp_i[b*BLK+HALF+k];
                sr = x0r + x1r;
                si = x0i + x1i;
                exp_q.push_back({sr, si});
            end
            for (int k = 0; k < HALF; k++) begin
                x0r = smp_drop[b*BLK+k] ? '0 : smp_r[b*BLK+k];
                x0i = smp_drop[b*BLK+k] ? '0 : smp_i[b*BLK+k];
                x1r = smp_drop[b*BLK+HALF+k] ? '0 : smp_r[b*BLK+HALF+k];
                x1i = smp_drop[b*BLK+HALF+k] ? '0 : smp_i[b*BLK+HALF+k];
                sr = x0r - x1r;
                si = x0i - x1i;
                pr = longint'(sr) * longint'(tw_r[k]) - longint'(si) * longint'(tw_i[k]);
                pi = longint'(sr) * longint'(tw_i[k]) + longint'(si) * longint'(tw_r[k]);
                pr = pr >>> FRAC;
                pi = pi >>> FRAC;
                orr = pr[DW-1:0];
                oi  = pi[DW-1:0];
                exp_q.push_back({orr, oi});
            end
        end
    endfunction

    task automatic clear_samples(input int nblk);
        smp_r.delete();
        smp_i.delete();
        smp_drop.delete();
        for (int i = 0; i < nblk * BLK; i++) begin
            smp_r.push_back('0);
            smp_i.push_back('0);
            smp_drop.push_back(1'b0);
        end
    endtask

    task automatic random_samples(input int nblk, input int drop_pct);
        clear_samples(nblk);
        for (int i = 0; i < nblk * BLK; i++) begin
            smp_r[i] = rnd_dw();
            smp_i[i] = rnd_dw();
            smp_drop[i] = (i >= HALF) && ($urandom_range(99) < drop_pct);
        end
    endtask

    // Scoreboard step: one clock of stimulus, then valid, data and hold checks.
    task automatic drive_cycle(input bit v, input logic signed [DW-1:0] dr, input logic signed [DW-1:0] di,
                               input logic [1:0] st, input logic signed [DW-1:0] wr,
                               input logic signed [DW-1:0] wi, input bit exp_v);
        logic [2*DW-1:0] e;
        if (aborted) return;
        if (cyc_cnt == abort_at) begin
            aborted = 1'b1;
            return;
        end
        bus.in_valid = v;
        bus.din_r    = dr;
        bus.din_i    = di;
        bus.state    = st;
        bus.w_r      = wr;
        bus.w_i      = wi;
        @(posedge clk);
        #1;
        total++;
        if (bus.out_valid !== exp_v) begin
            bad++;
            $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc_cnt, bus.out_valid, exp_v);
        end
        if (bus.out_valid === 1'b1) begin
            got_r.push_back(bus.dout_r);
            got_i.push_back(bus.dout_i);
            if (first_valid < 0) first_valid = cyc_cnt;
            last_valid = cyc_cnt;
            n_valid++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_underrun cyc=%0d got=%h/%h exp=none", cyc_cnt, bus.dout_r, bus.dout_i);
            end else begin
                e = exp_q.pop_front();
                if ({bus.dout_r, bus.dout_i} !== e) begin
                    bad++;
                    $display("FAIL sb_data cyc=%0d got=%h/%h exp=%h/%h", cyc_cnt, bus.dout_r, bus.dout_i,
                             e[2*DW-1:DW], e[DW-1:0]);
                end
            end
        end else begin
            total++;
            if (bus.dout_r !== last_r || bus.dout_i !== last_i) begin
                bad++;
                $display("FAIL dout_hold cyc=%0d got=%h/%h exp=%h/%h", cyc_cnt, bus.dout_r, bus.dout_i,
                         last_r, last_i);
            end
        end
        last_r = bus.dout_r;
        last_i = bus.dout_i;
        cyc_cnt++;
    endtask

    // ROM-like phase sequence: fill, then (butterfly, twiddle) per block; twiddle phase feeds the next block.
    task automatic run_sequence(input int nblk, input int gap_pct, input int st3_pct);
        int idx;
        logic [1:0] st;
        cyc_cnt = 0;
        first_valid = -1;
        last_valid = -1;
        n_valid = 0;
        aborted = 1'b0;
        got_r.delete();
        got_i.delete();
        build_model(nblk);
        idx = 0;
        while (idx < HALF && !aborted) begin
            st = ($urandom_range(99) < st3_pct) ? 2'd3 : 2'd0;
            if ($urandom_range(99) < gap_pct) begin
                drive_cycle(1'b0, rnd_dw(), rnd_dw(), st, rnd_dw(), rnd_dw(), 1'b0);
            end else begin
                drive_cycle(1'b1, smp_r[idx], smp_i[idx], st, rnd_dw(), rnd_dw(), 1'b0);
                idx++;
            end
        end
        for (int b = 0; b < nblk; b++) begin
            for (int k = 0; k < HALF; k++) begin
                idx = b * BLK + HALF + k;
                drive_cycle(!smp_drop[idx], smp_drop[idx] ? rnd_dw() : smp_r[idx],
                            smp_drop[idx] ? rnd_dw() : smp_i[idx], 2'd1, DW'(256), '0, 1'b1);
            end
            for (int k = 0; k < HALF; k++) begin
                idx = (b + 1) * BLK + k;
                if (idx < smp_r.size()) begin
                    drive_cycle(!smp_drop[idx], smp_drop[idx] ? rnd_dw() : smp_r[idx],
                                smp_drop[idx] ? rnd_dw() : smp_i[idx], 2'd2, tw_r[k], tw_i[k], 1'b1);
                end else begin
                    drive_cycle(1'b0, rnd_dw(), rnd_dw(), 2'd2, tw_r[k], tw_i[k], 1'b1);
                end
            end
        end
        repeat (2) drive_cycle(1'b0, rnd_dw(), rnd_dw(), 2'd0, rnd_dw(), rnd_dw(), 1'b0);
    endtask

    task automatic check_impulse_result(input string tag);
        int nz;
        total++;
        if (got_r[1] !== DW'(256) || got_i[1] !== '0) begin
            bad++;
            $display("FAIL %s_sum1 got=%0d/%0d exp=256/0", tag, got_r[1], got_i[1]);
        end
        total++;
        if (got_r[33] !== DW'(255) || got_i[33] !== DW'(-25)) begin
            bad++;
            $display("FAIL %s_twid1 got=%0d/%0d exp=255/-25", tag, got_r[33], got_i[33]);
        end
        nz = 0;
        for (int i = 0; i < got_r.size(); i++) begin
            if (i != 1 && i != 33 && (got_r[i] !== '0 || got_i[i] !== '0)) nz++;
        end
        total++;
        if (nz != 0 || n_valid != BLK) begin
            bad++;
            $display("FAIL %s_rest nonzero=%0d outputs=%0d exp=0/64", tag, nz, n_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.din_r = '0;
        bus.din_i = '0;
        bus.state = 2'd0;
        bus.w_r = '0;
        bus.w_i = '0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (bus.out_valid !== 1'b0 || bus.dout_r !== '0 || bus.dout_i !== '0) begin
            bad++;
            $display("FAIL reset_values got=%b/%h/%h exp=0/0/0", bus.out_valid, bus.dout_r, bus.dout_i);
        end
        rst = 1'b0;
        last_r = '0;
        last_i = '0;
    endtask

    task automatic test_impulse();
        clear_samples(1);
        smp_r[1] = DW'(256);
        run_sequence(1, 0, 0);
        check_impulse_result("impulse");
    endtask

    task automatic test_dc();
        int errs;
        clear_samples(1);
        for (int i = 0; i < BLK; i++) smp_r[i] = DW'(100);
        run_sequence(1, 0, 0);
        errs = 0;
        for (int i = 0; i < got_r.size(); i++) begin
            if (got_r[i] !== ((i < HALF) ? DW'(200) : DW'(0)) || got_i[i] !== '0) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL dc_values got_errors=%0d exp=0", errs);
        end
        total++;
        if (first_valid != HALF) begin
            bad++;
            $display("FAIL dc_first_valid got=%0d exp=%0d", first_valid, HALF);
        end
        total++;
        if (n_valid != BLK || last_valid - first_valid != BLK - 1) begin
            bad++;
            $display("FAIL dc_valid_run got=%0d span=%0d exp=64", n_valid, last_valid - first_valid + 1);
        end
    endtask

    task automatic test_second_half();
        clear_samples(1);
        smp_r[HALF] = DW'(256);
        run_sequence(1, 0, 0);
        total++;
        if (got_r[0] !== DW'(256) || got_i[0] !== '0) begin
            bad++;
            $display("FAIL half_sum0 got=%0d/%0d exp=256/0", got_r[0], got_i[0]);
        end
        total++;
        if (got_r[32] !== DW'(-256) || got_i[32] !== '0) begin
            bad++;
            $display("FAIL half_twid0 got=%0d/%0d exp=-256/0", got_r[32], got_i[32]);
        end
    endtask

    task automatic test_overflow();
        clear_samples(1);
        smp_r[0] = 24'h7FFFFF;
        smp_r[HALF] = 24'h7FFFFF;
        run_sequence(1, 0, 0);
        total++;
        if (got_r[0] !== 24'hFFFFFE || got_i[0] !== '0) begin
            bad++;
            $display("FAIL wrap_sum0 got=%h/%h exp=fffffe/000000", got_r[0], got_i[0]);
        end
        total++;
        if (got_r[32] !== '0 || got_i[32] !== '0) begin
            bad++;
            $display("FAIL wrap_twid0 got=%h/%h exp=000000/000000", got_r[32], got_i[32]);
        end
    endtask

    task automatic test_back_to_back();
        logic signed [DW-1:0] s2_r;
        random_samples(2, 0);
        s2_r = smp_r[BLK] + smp_r[BLK+HALF];
        run_sequence(2, 0, 0);
        total++;
        if (n_valid != 2 * BLK || last_valid - first_valid != 2 * BLK - 1) begin
            bad++;
            $display("FAIL b2b_valid_run got=%0d span=%0d exp=128", n_valid, last_valid - first_valid + 1);
        end
        total++;
        if (got_r[BLK] !== s2_r) begin
            bad++;
            $display("FAIL b2b_blk2_sum0 got=%h exp=%h", got_r[BLK], s2_r);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            random_samples(3, 15);
            run_sequence(3, 25, 20);
            total++;
            if (exp_q.size() != 0 || n_valid != 3 * BLK) begin
                bad++;
                $display("FAIL rand_count round=%0d got=%0d left=%0d exp=192/0", r, n_valid, exp_q.size());
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_samples(1);
        smp_r[1] = DW'(256);
        abort_at = 40;
        run_sequence(1, 0, 0);
        abort_at = -1;
        bus.in_valid = 1'b1;
        bus.din_r = rnd_dw();
        bus.din_i = rnd_dw();
        bus.state = 2'd1;
        bus.w_r = DW'(256);
        bus.w_i = '0;
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (bus.out_valid !== 1'b0 || bus.dout_r !== '0 || bus.dout_i !== '0) begin
            bad++;
            $display("FAIL midreset_async got=%b/%h/%h exp=0/0/0", bus.out_valid, bus.dout_r, bus.dout_i);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        last_r = '0;
        last_i = '0;
        clear_samples(1);
        smp_r[1] = DW'(256);
        run_sequence(1, 0, 0);
        check_impulse_result("midreset");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        abort_at = -1;
        aborted = 1'b0;
        for (int k = 0; k < HALF; k++) begin
            tw_r[k] = DW'(int'($floor(256.0 * $cos(2.0 * 3.14159265358979 * k / 64.0) + 0.5)));
            tw_i[k] = DW'(int'($floor(-256.0 * $sin(2.0 * 3.14159265358979 * k / 64.0) + 0.5)));
        end
        test_reset();
        test_impulse();
        test_dc();
        test_second_half();
        test_overflow();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
